// File: rtl/alu_issue_stage_pkg.sv
// Shared types and constants for the ALU issue stage.
// Holds opcodes, widths, FSM encoding and the ID->EX bundle.
package alu_issue_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOR = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_MUL = 4'd8,
        ALU_SLT = 4'd9
    } alu_op_t;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_control;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        shamt;
        logic [REG_W-1:0]  dest;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [DATA_W-1:0] store_data;
    } id_ex_t;

    function automatic logic [DATA_W-1:0] ext_imm(
        input logic [15:0] imm,
        input logic        sgn
    );
        return sgn ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Operand forwarding mux: held EX result, then MEM, then WB.
// Register 0 never forwards; it always reads the register file.
module alu_fwd_mux
    import alu_issue_stage_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              ex_ok,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);

    logic nz;

    assign nz = (src != '0);

    always_comb begin
        data = reg_data;
        if (nz && ex_ok && ex_dest == src)
            data = ex_data;
        else if (nz && mem_reg_write && mem_rd == src)
            data = mem_data;
        else if (nz && wb_reg_write && wb_rd == src)
            data = wb_data;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register with forwarding and load-use stall.
// A load-use hazard inserts exactly one bubble and is counted.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_control,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_alu_src,
    input  logic              id_ext_signed,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_control,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [4:0]        ex_shamt,
    output logic [REG_W-1:0]  ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [15:0]       stall_count
);

    state_t            state;
    id_ex_t            ex;
    id_ex_t            nxt;
    logic              ex_ok;
    logic              hazard;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // A load in EX has no result yet, so it must not forward.
    assign ex_ok = ex.valid & ex.reg_write & ~ex.mem_read;

    alu_fwd_mux u_fwd_rs (
        .src           (id_rs),
        .reg_data      (id_rs_data),
        .ex_ok         (ex_ok),
        .ex_dest       (ex.dest),
        .ex_data       (alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .data          (fwd_rs)
    );

    alu_fwd_mux u_fwd_rt (
        .src           (id_rt),
        .reg_data      (id_rt_data),
        .ex_ok         (ex_ok),
        .ex_dest       (ex.dest),
        .ex_data       (alu_result),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .data          (fwd_rt)
    );

    assign hazard = ex.valid & ex.mem_read & (ex.dest != '0) & id_valid &
                    ((ex.dest == id_rs) |
                     ((ex.dest == id_rt) & (~id_alu_src | id_mem_write)));

    assign stall = (state == RUN) & hazard & ~flush;

    always_comb begin
        nxt = '0;
        if (id_valid && !flush && !stall) begin
            nxt.valid       = 1'b1;
            nxt.alu_control = id_alu_control;
            nxt.a           = fwd_rs;
            nxt.b           = id_alu_src ? ext_imm(id_imm, id_ext_signed)
                                         : fwd_rt;
            nxt.shamt       = id_shamt;
            nxt.dest        = id_reg_dst ? id_rd : id_rt;
            nxt.reg_write   = id_reg_write;
            nxt.mem_read    = id_mem_read;
            nxt.mem_write   = id_mem_write;
            nxt.store_data  = fwd_rt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ex          <= '0;
            state       <= RUN;
            stall_count <= '0;
        end else begin
            ex    <= nxt;
            state <= stall ? BUBBLE : RUN;
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

    assign ex_valid       = ex.valid;
    assign ex_alu_control = ex.alu_control;
    assign ex_a           = ex.a;
    assign ex_b           = ex.b;
    assign ex_shamt       = ex.shamt;
    assign ex_dest        = ex.dest;
    assign ex_reg_write   = ex.reg_write;
    assign ex_mem_read    = ex.mem_read;
    assign ex_mem_write   = ex.mem_write;
    assign ex_store_data  = ex.store_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: cycle model plus directed literal checks.
// The model also plays the ALU, feeding alu_result from its own EX view.
module tb_alu_issue_stage;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        id_valid = 0;
    logic [3:0]  id_alu_control = 0;
    logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0;
    logic [31:0] id_rs_data = 0, id_rt_data = 0;
    logic [15:0] id_imm = 0;
    logic [4:0]  id_shamt = 0;
    logic        id_alu_src = 0, id_ext_signed = 0, id_reg_dst = 0;
    logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0;
    logic        flush = 0;
    logic [31:0] alu_result;
    logic        mem_reg_write = 0, wb_reg_write = 0;
    logic [4:0]  mem_rd = 0, wb_rd = 0;
    logic [31:0] mem_data = 0, wb_data = 0;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_shamt, ex_dest;
    logic [15:0] stall_count;

    int n_checks = 0;
    int n_fail = 0;

    // Model of what EX must hold, plus bubble counter.
    logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0, m_stalled = 0;
    logic [3:0]  m_ctrl = 0;
    logic [31:0] m_a = 0, m_b = 0, m_sd = 0;
    logic [4:0]  m_shamt = 0, m_dest = 0;
    logic [15:0] m_cnt = 0;
    logic        n_valid = 0, n_rw = 0, n_mr = 0, n_mw = 0, n_stalled = 0;
    logic [3:0]  n_ctrl = 0;
    logic [31:0] n_a = 0, n_b = 0, n_sd = 0;
    logic [4:0]  n_shamt = 0, n_dest = 0;
    logic [15:0] n_cnt = 0;

    always #5 Clk = ~Clk;

    alu_issue_stage dut (
        .Clk(Clk), .Rst(Rst), .id_valid(id_valid),
        .id_alu_control(id_alu_control),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_alu_src(id_alu_src),
        .id_ext_signed(id_ext_signed), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .flush(flush),
        .alu_result(alu_result),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_data(mem_data),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b),
        .ex_shamt(ex_shamt), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
        .stall_count(stall_count)
    );

    function automatic logic [31:0] alu_fn(
        input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] sh);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return ~(a | b);
            4'd5: return a ^ b;
            4'd6: return b << sh;
            4'd7: return b >> sh;
            4'd8: return a * b;
            4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(m_ctrl, m_a, m_b, m_shamt);

    function automatic logic [31:0] mfwd(
        input logic [4:0] r, input logic [31:0] d);
        if (r == 5'd0) return d;
        if (m_valid && m_rw && !m_mr && m_dest == r) return alu_result;
        if (mem_reg_write && mem_rd == r) return mem_data;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: inputs are stable at the falling edge.
    always @(negedge Clk) begin
        logic        hz, st, go;
        logic [31:0] ra, rb;
        hz = m_valid && m_mr && m_dest != 0 && id_valid &&
             (m_dest == id_rs ||
              (m_dest == id_rt && (!id_alu_src || id_mem_write)));
        st = !m_stalled && hz && !flush;
        check("stall", {31'd0, stall}, {31'd0, st});
        check("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        check("ex_alu_control", {28'd0, ex_alu_control}, {28'd0, m_ctrl});
        check("ex_a", ex_a, m_a);
        check("ex_b", ex_b, m_b);
        check("ex_shamt", {27'd0, ex_shamt}, {27'd0, m_shamt});
        check("ex_dest", {27'd0, ex_dest}, {27'd0, m_dest});
        check("ex_ctl", {29'd0, ex_reg_write, ex_mem_read, ex_mem_write},
              {29'd0, m_rw, m_mr, m_mw});
        check("ex_store_data", ex_store_data, m_sd);
        check("stall_count", {16'd0, stall_count}, {16'd0, m_cnt});
        go = id_valid && !flush && !st;
        ra = mfwd(id_rs, id_rs_data);
        rb = mfwd(id_rt, id_rt_data);
        n_valid   <= go;
        n_ctrl    <= go ? id_alu_control : 4'd0;
        n_a       <= go ? ra : 32'd0;
        n_b       <= !go ? 32'd0 : !id_alu_src ? rb :
                     id_ext_signed ? {{16{id_imm[15]}}, id_imm}
                                   : {16'd0, id_imm};
        n_shamt   <= go ? id_shamt : 5'd0;
        n_dest    <= !go ? 5'd0 : id_reg_dst ? id_rd : id_rt;
        n_rw      <= go && id_reg_write;
        n_mr      <= go && id_mem_read;
        n_mw      <= go && id_mem_write;
        n_sd      <= go ? rb : 32'd0;
        n_stalled <= st;
        n_cnt     <= (st && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
    end

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_valid <= 0; m_ctrl <= 0; m_a <= 0; m_b <= 0;
            m_shamt <= 0; m_dest <= 0; m_rw <= 0; m_mr <= 0;
            m_mw <= 0; m_sd <= 0; m_stalled <= 0; m_cnt <= 0;
        end else begin
            m_valid <= n_valid; m_ctrl <= n_ctrl; m_a <= n_a;
            m_b <= n_b; m_shamt <= n_shamt; m_dest <= n_dest;
            m_rw <= n_rw; m_mr <= n_mr; m_mw <= n_mw; m_sd <= n_sd;
            m_stalled <= n_stalled; m_cnt <= n_cnt;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic dst, input logic rw, input logic mr,
                         input logic mw, input logic src);
        id_valid = 1; id_alu_control = op;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd;
        id_reg_dst = dst; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_alu_src = src;
    endtask

    task automatic idle();
        id_valid = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_reg_write = 0; wb_reg_write = 0; flush = 0;
    endtask

    initial begin
        #2 Rst = 0;
        tick();
        tick();
        check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("rst stall_count", {16'd0, stall_count}, 32'd0);
        Rst = 1;

        // add r3,r1,r2 then sub r4,r3,r1: r3 from held ALU result.
        instr(4'd0, 5'd1, 5'd2, 5'd3, 32'd8, 32'd8, 1, 1, 0, 0, 0);
        tick();
        instr(4'd1, 5'd3, 5'd1, 5'd4, 32'd0, 32'd8, 1, 1, 0, 0, 0);
        tick();
        check("sub ex_a", ex_a, 32'h10);
        check("sub ex_b", ex_b, 32'h8);
        idle();
        tick();

        // lw r5 then add r6,r5,r2: one bubble, then forward from MEM.
        instr(4'd0, 5'd2, 5'd5, 5'd0, 32'h100, 32'd0, 0, 1, 1, 0, 1);
        id_imm = 16'd4; id_ext_signed = 1;
        tick();
        instr(4'd0, 5'd5, 5'd2, 5'd6, 32'd0, 32'd3, 1, 1, 0, 0, 0);
        #1 check("lu stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu bubble", {31'd0, ex_valid}, 32'd0);
        check("lu stall drop", {31'd0, stall}, 32'd0);
        mem_reg_write = 1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
        tick();
        check("lu ex_a", ex_a, 32'hDEADBEEF);
        check("lu ex_valid", {31'd0, ex_valid}, 32'd1);
        check("lu count", {16'd0, stall_count}, 32'd1);
        idle();
        tick();

        // r0 written at every level still reads the register file.
        instr(4'd0, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 1, 1, 0, 0, 0);
        tick();
        instr(4'd0, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 1, 1, 0, 0, 0);
        mem_reg_write = 1; mem_rd = 5'd0; mem_data = 32'h55;
        wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h55;
        tick();
        check("r0 ex_a", ex_a, 32'd0);
        check("r0 store", ex_store_data, 32'd0);

        // MEM beats WB; zero and sign extension of 0x8000.
        instr(4'd3, 5'd7, 5'd8, 5'd0, 32'd0, 32'd0, 0, 1, 0, 0, 1);
        id_imm = 16'h8000; id_ext_signed = 0;
        mem_rd = 5'd7; mem_data = 32'hAAAA;
        wb_rd = 5'd7; wb_data = 32'hBBBB;
        tick();
        check("mem>wb ex_a", ex_a, 32'hAAAA);
        check("zext ex_b", ex_b, 32'h00008000);
        id_ext_signed = 1; mem_reg_write = 0;
        tick();
        check("wb ex_a", ex_a, 32'hBBBB);
        check("sext ex_b", ex_b, 32'hFFFF8000);
        check("held rt fwd", ex_store_data, 32'h0000AAAA);
        idle();
        tick();

        // Load feeding rt: immediate use is safe, a store is not.
        instr(4'd0, 5'd0, 5'd11, 5'd0, 32'd0, 32'd0, 0, 1, 1, 0, 1);
        tick();
        instr(4'd0, 5'd0, 5'd11, 5'd0, 32'd0, 32'd0, 0, 1, 0, 0, 1);
        #1 check("rt imm no stall", {31'd0, stall}, 32'd0);
        id_mem_write = 1; id_reg_write = 0;
        #1 check("rt store stall", {31'd0, stall}, 32'd1);
        idle();
        tick();

        // Hazard with flush: no stall, bubble, count unchanged.
        instr(4'd0, 5'd0, 5'd9, 5'd0, 32'd0, 32'd0, 0, 1, 1, 0, 1);
        tick();
        instr(4'd0, 5'd9, 5'd1, 5'd2, 32'd0, 32'd0, 1, 1, 0, 0, 0);
        flush = 1;
        #1 check("flush stall", {31'd0, stall}, 32'd0);
        tick();
        check("flush bubble", {31'd0, ex_valid}, 32'd0);
        check("flush count", {16'd0, stall_count}, 32'd1);
        idle();
        tick();

        // Reset during a stall drops the bubble.
        instr(4'd0, 5'd0, 5'd10, 5'd0, 32'd0, 32'd0, 0, 1, 1, 0, 1);
        tick();
        instr(4'd2, 5'd10, 5'd1, 5'd12, 32'd5, 32'd6, 1, 1, 0, 0, 0);
        #1 check("pre-rst stall", {31'd0, stall}, 32'd1);
        Rst = 0;
        #1;
        check("mid rst ex_valid", {31'd0, ex_valid}, 32'd0);
        check("mid rst ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
        check("mid rst ex_dest", {27'd0, ex_dest}, 32'd0);
        check("mid rst stall", {31'd0, stall}, 32'd0);
        check("mid rst count", {16'd0, stall_count}, 32'd0);
        #1 Rst = 1;
        tick();
        check("post rst ex_valid", {31'd0, ex_valid}, 32'd1);
        check("post rst ex_dest", {27'd0, ex_dest}, 32'd12);
        check("post rst ex_a", ex_a, 32'd5);
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Rst  in  1  asynchronous, active-low reset.
REQ-003 id_valid  in  1  decode stage holds a valid instruction.
REQ-004 id_alu_control  in  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 xor, 6 sll, 7 srl, 8 mul, 9 slt.
REQ-005 id_rs, id_rt, id_rd  in  5 each  source/destination register numbers.
REQ-006 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-007 id_imm  in  16; id_shamt  in  5; id_alu_src  in  1 (1 = B from immediate); id_ext_signed  in  1 (1 = sign-extend imm, 0 = zero-extend).
REQ-008 id_reg_dst  in  1 (1 = dest rd, 0 = rt); id_reg_write, id_mem_read, id_mem_write  in  1 each.
REQ-009 flush  in  1  squash instruction entering this stage.
REQ-010 alu_result  in  32  combinational ALU output for the instruction currently held here.
REQ-011 mem_reg_write  in  1; mem_rd  in  5; mem_data  in  32  producer two ahead (final value, load data included).
REQ-012 wb_reg_write  in  1; wb_rd  in  5; wb_data  in  32  producer three ahead.
REQ-013 stall  out  1  hold decode/fetch this cycle.
REQ-014 ex_valid  out 1; ex_alu_control  out 4; ex_a, ex_b  out 32; ex_shamt  out 5; ex_dest  out 5; ex_reg_write, ex_mem_read, ex_mem_write  out 1; ex_store_data  out 32 -- registered, feed ALU and downstream.
REQ-015 stall_count  out 16  saturating count of load-use bubbles.

Function
REQ-016 Forward each source (rs; rt) with priority: held instruction (ex_valid & ex_reg_write & ex_dest match, not load) -> alu_result; else mem match -> mem_data; else wb match -> wb_data; else register data.
REQ-017 Register 0 SHALL never match any forwarding source; operand reads id_*_data.
REQ-018 ex_a = forwarded rs; ex_store_data = forwarded rt; ex_b = extended imm when id_alu_src=1, else forwarded rt.
REQ-019 ex_shamt = id_shamt; ex_dest = id_reg_dst ? id_rd : id_rt.
REQ-020 Load-use hazard: ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | (ex_dest==id_rt & (id_alu_src==0 | id_mem_write))).
REQ-021 FSM states RUN, BUBBLE; RUN + hazard & !flush -> BUBBLE, stall=1 combinationally, bubble captured; BUBBLE -> RUN unconditionally next cycle, stall=0.
REQ-022 Bubble = ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_control all 0; data outputs 0.
REQ-023 flush has priority over hazard: bubble captured, stall=0, FSM to RUN.
REQ-024 id_valid=0 captures a bubble; latency ID->ex_* exactly one cycle when not stalled.
REQ-025 stall_count increments once per BUBBLE entry, saturates at 0xFFFF.

Reset
REQ-026 Rst low: every output 0, FSM RUN, stall_count 0, immediately and independent of Clk.
REQ-027 Reset mid-stall discards the pending bubble; first post-reset edge captures decode normally.

Structure
REQ-028 Shared package holds ALU opcode constants (0-9), 32-bit data width, 5-bit register width, FSM state encoding.
REQ-029 One sub-module alu_fwd_mux (instantiated twice, rs and rt) implements REQ-016/017.

Verification
REQ-030 Reset: Rst low during traffic -> all outputs 0, stall_count 0 within same cycle.
REQ-031 add r3 then sub r4,r3,r1: alu_result=0x10 -> ex_a=0x10 in second instruction's EX cycle.
REQ-032 lw r5 then add r6,r5,r2 -> stall=1 one cycle, one bubble (ex_valid=0), add issues with ex_a=mem_data=0xDEADBEEF, stall_count=1.
REQ-033 Producer writes r0=0x55 at all three levels, consumer reads r0 -> ex_a=id_rs_data=0.
REQ-034 mem and wb both target r7 (0xAAAA, 0xBBBB) -> ex_a=0xAAAA; ori with imm 0x8000 ext_signed=0 -> ex_b=0x00008000, ext_signed=1 -> 0xFFFF8000.
REQ-035 Load-use hazard with flush same cycle -> stall=0, bubble, stall_count unchanged.
